// File: rtl/switch_alloc_4port_if.sv
// ============================================================================
// Module      : switch_alloc_4port_if
// Description : Allocator-side bundle between route compute, switch allocator
//               and crossbar of the 4-port mesh router.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface switch_alloc_4port_if #(
    parameter int NPORT = 4,
    parameter int SELW  = 2
);
    logic                     en;
    logic [NPORT-1:0]         in_valid;
    logic [NPORT-1:0]         in_head;
    logic [NPORT-1:0]         in_tail;
    logic [3*NPORT-1:0]       in_port;
    logic [NPORT-1:0]         out_ready;
    logic [NPORT-1:0]         in_accept;
    logic [NPORT-1:0]         out_valid;
    logic [NPORT*SELW-1:0]    xbar_sel;
    logic [NPORT-1:0]         out_busy;

    modport master (
        output en, in_valid, in_head, in_tail, in_port, out_ready,
        input  in_accept, out_valid, xbar_sel, out_busy
    );

    modport slave (
        input  en, in_valid, in_head, in_tail, in_port, out_ready,
        output in_accept, out_valid, xbar_sel, out_busy
    );
endinterface

`default_nettype wire

// File: rtl/switch_alloc_4port.sv
// ============================================================================
// Module      : switch_alloc_4port
// Description : Round-robin switch allocator; locks each output to a packet
//               from head grant until its tail flit transfers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_alloc_4port #(
    parameter int NPORT = 4,
    parameter int SELW  = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    switch_alloc_4port_if.slave bus
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t            r_state   [NPORT];
    state_t            w_state_nxt [NPORT];
    logic [SELW-1:0]   r_sel     [NPORT];
    logic [SELW-1:0]   w_sel_nxt [NPORT];
    logic [SELW-1:0]   r_ptr     [NPORT];
    logic [SELW-1:0]   w_ptr_nxt [NPORT];
    logic [NPORT-1:0]  w_req     [NPORT];
    logic [SELW-1:0]   w_win     [NPORT];
    logic [NPORT-1:0]  w_found;
    logic [NPORT-1:0]  w_xfer;

    // Route code k (1..4) targets output k-1; EMPTY and 5..7 never match.
    always_comb begin
        for (int o = 0; o < NPORT; o++) begin
            for (int i = 0; i < NPORT; i++) begin
                w_req[o][i] = bus.in_valid[i] & bus.in_head[i] &
                              (bus.in_port[3*i +: 3] == 3'(o + 1));
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NPORT; o++) begin
            w_win[o]   = '0;
            w_found[o] = 1'b0;
            for (int k = 0; k < NPORT; k++) begin
                if (!w_found[o] && w_req[o][r_ptr[o] + SELW'(k)]) begin
                    w_win[o]   = r_ptr[o] + SELW'(k);
                    w_found[o] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.in_accept = '0;
        bus.out_valid = '0;
        w_xfer        = '0;
        for (int o = 0; o < NPORT; o++) begin
            if (r_state[o] == S_LOCKED) begin
                bus.out_valid[o] = bus.in_valid[r_sel[o]];
                w_xfer[o]        = bus.in_valid[r_sel[o]] & bus.out_ready[o];
                if (w_xfer[o]) begin
                    bus.in_accept[r_sel[o]] = 1'b1;
                end
            end
        end
    end

    // Release happens only in LOCKED, grant only in IDLE, so a released
    // output needs one full IDLE cycle before it can grant again.
    always_comb begin
        for (int o = 0; o < NPORT; o++) begin
            w_state_nxt[o] = r_state[o];
            w_sel_nxt[o]   = r_sel[o];
            w_ptr_nxt[o]   = r_ptr[o];
            case (r_state[o])
                S_IDLE: begin
                    if (bus.en && w_found[o]) begin
                        w_state_nxt[o] = S_LOCKED;
                        w_sel_nxt[o]   = w_win[o];
                    end
                end
                S_LOCKED: begin
                    if (w_xfer[o] && bus.in_tail[r_sel[o]]) begin
                        w_state_nxt[o] = S_IDLE;
                        w_ptr_nxt[o]   = r_sel[o] + SELW'(1);
                    end
                end
                default: begin
                    w_state_nxt[o] = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < NPORT; o++) begin
                r_state[o] <= S_IDLE;
                r_sel[o]   <= '0;
                r_ptr[o]   <= '0;
            end
        end else begin
            for (int o = 0; o < NPORT; o++) begin
                r_state[o] <= w_state_nxt[o];
                r_sel[o]   <= w_sel_nxt[o];
                r_ptr[o]   <= w_ptr_nxt[o];
            end
        end
    end

    generate
        for (genvar o = 0; o < NPORT; o++) begin : g_out
            assign bus.xbar_sel[o*SELW +: SELW] = r_sel[o];
            assign bus.out_busy[o]              = (r_state[o] == S_LOCKED);
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_switch_alloc_4port.sv
// ============================================================================
// Module      : tb_switch_alloc_4port
// Description : Scoreboard bench for switch_alloc_4port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_switch_alloc_4port;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    switch_alloc_4port_if bus_if ();

    switch_alloc_4port dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct packed {
        logic       head;
        logic       tail;
        logic [2:0] code;
    } flit_t;

    localparam flit_t c_h1 = '{head: 1'b1, tail: 1'b1, code: 3'd0};

    flit_t      s_q   [4][$];
    int         exp_q [4][$];
    logic [3:0] bub_v   = 4'h0;
    logic [3:0] rdy_v   = 4'hF;
    logic [3:0] rel_chk = 4'h0;
    logic       en_v    = 1'b1;
    logic       rst_v   = 1'b1;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
        end
    endtask

    function automatic flit_t mk(input logic h, input logic t, input logic [2:0] c);
        flit_t f;
        f.head = h;
        f.tail = t;
        f.code = c;
        return f;
    endfunction

    task automatic push_pkt(input int i, input int len, input logic [2:0] c);
        for (int k = 0; k < len; k++) begin
            s_q[i].push_back(mk(k == 0, k == len - 1, c));
        end
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < 4; i++) n += s_q[i].size() + exp_q[i].size();
        return n;
    endfunction

    task automatic drive();
        logic [3:0]  v = '0;
        logic [3:0]  h = '0;
        logic [3:0]  t = '0;
        logic [11:0] p = '0;
        flit_t       f;
        for (int i = 0; i < 4; i++) begin
            if (s_q[i].size() > 0 && !bub_v[i]) begin
                f = s_q[i][0];
                v[i] = 1'b1;
                h[i] = f.head;
                t[i] = f.tail;
                p[3*i +: 3] = f.code;
            end
        end
        rst                = rst_v;
        bus_if.en          = en_v;
        bus_if.out_ready   = rdy_v;
        bus_if.in_valid    = v;
        bus_if.in_head     = h;
        bus_if.in_tail     = t;
        bus_if.in_port     = p;
    endtask

    // Every accepted flit is matched against the expected owner sequence
    // of the output its route code names.
    task automatic monitor();
        flit_t f;
        int    o;
        for (int k = 0; k < 4; k++) begin
            if (rel_chk[k]) begin
                chk("release", 32'(bus_if.out_busy[k]), 32'd0);
                rel_chk[k] = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (bus_if.in_accept[i] === 1'b1) begin
                if (s_q[i].size() == 0) begin
                    chk("spurious_acc", 32'(i) + 32'd1, 32'd0);
                end else begin
                    f = s_q[i].pop_front();
                    if (f.code < 3'd1 || f.code > 3'd4) begin
                        chk("illegal_acc", 32'(f.code), 32'd0);
                    end else begin
                        o = int'(f.code) - 1;
                        chk("xfer_sel", 32'(bus_if.xbar_sel[2*o +: 2]), 32'(i));
                        chk("xfer_oval", 32'(bus_if.out_valid[o]), 32'd1);
                        if (exp_q[o].size() == 0)
                            chk("unexp_xfer", 32'(i) + 32'd1, 32'd0);
                        else
                            chk("xfer_order", 32'(i), 32'(exp_q[o].pop_front()));
                        if (f.tail) rel_chk[o] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        monitor();
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (pending() != 0 && n < bound) begin
            step();
            n++;
        end
        chk("drain", 32'(pending()), 32'd0);
        step();
    endtask

    initial begin
        drive();

        // Reset held while a request is pending, then the first grant.
        push_pkt(1, 1, 3'd4);
        exp_q[3].push_back(1);
        repeat (2) begin
            step();
            chk("rst_busy", 32'(bus_if.out_busy), 32'd0);
            chk("rst_sel", 32'(bus_if.xbar_sel), 32'd0);
            chk("rst_acc", 32'(bus_if.in_accept), 32'd0);
        end
        rst_v = 1'b0;
        step();
        chk("arb_busy", 32'(bus_if.out_busy), 32'd0);
        chk("arb_acc", 32'(bus_if.in_accept), 32'd0);
        step();
        chk("gnt_busy", 32'(bus_if.out_busy), 32'h8);
        chk("gnt_sel", 32'(bus_if.xbar_sel[7:6]), 32'd1);
        step();

        // Round-robin among three continuous single-flit requesters.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin
                push_pkt(i, 1, 3'd1);
                exp_q[0].push_back(i);
            end
        end
        drain(60);

        // Lock held across a 3-flit packet while another input waits.
        push_pkt(2, 3, 3'd3);
        exp_q[2].push_back(2);
        exp_q[2].push_back(2);
        exp_q[2].push_back(2);
        exp_q[2].push_back(0);
        step();
        push_pkt(0, 1, 3'd3);
        step();
        chk("lock_hold", 32'(bus_if.in_accept[0]), 32'd0);
        chk("lock_sel", 32'(bus_if.xbar_sel[5:4]), 32'd2);
        drain(40);

        // Backpressure then bubbles in the middle of a packet.
        push_pkt(1, 3, 3'd2);
        for (int k = 0; k < 3; k++) exp_q[1].push_back(1);
        step();
        step();
        rdy_v[1] = 1'b0;
        repeat (3) begin
            step();
            chk("bp_acc", 32'(bus_if.in_accept), 32'd0);
            chk("bp_busy", 32'(bus_if.out_busy[1]), 32'd1);
            chk("bp_oval", 32'(bus_if.out_valid[1]), 32'd1);
        end
        rdy_v = 4'hF;
        bub_v[1] = 1'b1;
        repeat (2) begin
            step();
            chk("bub_acc", 32'(bus_if.in_accept), 32'd0);
            chk("bub_busy", 32'(bus_if.out_busy[1]), 32'd1);
            chk("bub_oval", 32'(bus_if.out_valid[1]), 32'd0);
        end
        bub_v = 4'h0;
        drain(20);

        // Arbitration disabled while a request waits on an idle output.
        en_v = 1'b0;
        push_pkt(3, 1, 3'd1);
        exp_q[0].push_back(3);
        repeat (3) begin
            step();
            chk("en_busy", 32'(bus_if.out_busy), 32'd0);
            chk("en_acc", 32'(bus_if.in_accept), 32'd0);
        end
        en_v = 1'b1;
        step();
        chk("en_arb", 32'(bus_if.out_busy), 32'd0);
        drain(10);

        // Illegal and empty route codes never request.
        s_q[0].push_back(mk(1'b1, 1'b1, 3'd6));
        s_q[2].push_back(mk(c_h1.head, c_h1.tail, c_h1.code));
        repeat (4) begin
            step();
            chk("ill_busy", 32'(bus_if.out_busy), 32'd0);
            chk("ill_acc", 32'(bus_if.in_accept), 32'd0);
        end
        s_q[0].delete();
        s_q[2].delete();

        // Reset in the middle of a locked packet drops the lock.
        push_pkt(3, 3, 3'd2);
        exp_q[1].push_back(3);
        step();
        step();
        rdy_v[1] = 1'b0;
        step();
        rst_v = 1'b1;
        step();
        rst_v = 1'b0;
        rdy_v = 4'hF;
        repeat (3) begin
            step();
            chk("rstm_busy", 32'(bus_if.out_busy), 32'd0);
            chk("rstm_acc", 32'(bus_if.in_accept), 32'd0);
            chk("rstm_sel", 32'(bus_if.xbar_sel), 32'd0);
        end
        s_q[3].delete();
        chk("rstm_exp", 32'(exp_q[1].size()), 32'd0);

        // Simultaneous independent grants including U-turns.
        push_pkt(0, 1, 3'd1);
        push_pkt(3, 1, 3'd4);
        push_pkt(1, 1, 3'd3);
        exp_q[0].push_back(0);
        exp_q[3].push_back(3);
        exp_q[2].push_back(1);
        step();
        chk("sim_arb", 32'(bus_if.out_busy), 32'd0);
        step();
        chk("sim_busy", 32'(bus_if.out_busy), 32'hD);
        chk("sim_acc", 32'(bus_if.in_accept), 32'hB);
        step();
        chk("sim_done", 32'(pending()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/switch_alloc_4port.md
Name: switch_alloc_4port

Overview:
- Per-router switch allocator for the 4-port mesh router. Sits between the route-compute stage and the crossbar.
- Each input presents the 3-bit output port code produced by route compute. The allocator arbitrates each output port round-robin among head flits requesting it, then locks that output to the winner until the tail flit transfers.
- Drives crossbar select lines and the per-input flit-accept strobes.

Parameters:
- NPORT, 4, number of input/output ports (index 0=LOCAL, 1=X1, 2=X2, 3=Y1); fixed at 4.
- SELW, 2, width of one crossbar select field.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  arbitration enable; gates new grants only.
- in_valid  input  4  flit present at input i.
- in_head  input  4  flit at input i is a head flit.
- in_tail  input  4  flit at input i is a tail flit (head+tail = single-flit packet).
- in_port  input  12  3-bit route code for input i at bits [3i+2:3i]; global defines EMPTY=3'd0, OUT_LOCAL_PORT=3'd1, OUT_X1_PORT=3'd2, OUT_X2_PORT=3'd3, OUT_Y1_PORT=3'd4.
- out_ready  input  4  downstream of output o can accept a flit.
- in_accept  output  4  combinational: flit at input i transfers this cycle.
- out_valid  output  4  combinational: flit driven on output o this cycle.
- xbar_sel  output  8  registered: input index owning output o at bits [2o+1:2o].
- out_busy  output  4  registered: output o locked to a packet.

Behaviour:
- Reset (rst=1 at a clk edge): all outputs IDLE, xbar_sel=0, out_busy=0, all rr pointers=0. in_accept/out_valid evaluate to 0 because nothing is locked. Reset mid-packet drops the lock; no flit is accepted afterwards.
- Code mapping: code k in 1..4 targets output k-1. EMPTY and codes 5..7 are ignored (never request, never accepted).
- Per-output FSM, independent per o:
  - IDLE: request set R = {i : in_valid[i] & in_head[i] & code(i)->o}. If en=1 and R is non-empty, winner = first set bit of R scanning from ptr[o] upward, modulo 4. Next cycle: LOCKED, xbar_sel[o]=winner, out_busy[o]=1. One-cycle arbitration latency; no transfer happens in the arbitration cycle.
  - LOCKED(owner): out_valid[o] = in_valid[owner]; in_accept[owner] = in_valid[owner] & out_ready[o].
    - On a transfer with in_tail[owner]=1: next state IDLE, out_busy[o]=0, ptr[o]=(owner+1) mod 4, xbar_sel holds its value.
    - Otherwise stay LOCKED. Bubbles (in_valid=0) and backpressure (out_ready=0) hold the lock indefinitely.
- Ownership: an input is owned by at most one output, because it requests only its own code. While locked, the owner's later flits (body/tail) are not re-checked against in_port.
- en=0: IDLE outputs do not grant. LOCKED outputs continue transferring and release normally.
- Release and re-grant never overlap: an output released on cycle t can grant at the edge ending cycle t+1 at the earliest. No same-cycle re-arbitration.
- Single-flit packet: grant, then transfer on the first cycle with valid&ready, then release at that edge.
- ptr wrap: a pointer of 3 scans 3,0,1,2.
- U-turn (input i requesting output i) is legal and treated like any other request.
- Simultaneous grants to different outputs in one cycle are independent.

Test Plan:
- Reset: assert rst for 2 cycles while driving requests -> out_busy=0, xbar_sel=0, in_accept=0. First grant appears one cycle after rst falls.
- Single requester: input 1 head+tail, code OUT_Y1_PORT(4), out_ready=4'hF -> next cycle out_busy[3]=1, xbar_sel[7:6]=1; in_accept[1]=1 that cycle; out_busy[3]=0 after the edge; ptr[3]=2.
- Round-robin: inputs 0,1,2 all send continuous single-flit packets to code OUT_LOCAL_PORT(1) -> grant order 0,1,2,0,… on xbar_sel[1:0], each grant separated by one arbitration cycle.
- Lock across packet: input 2 sends head, body, tail to OUT_X2_PORT(3), and input 0 requests the same output mid-packet -> xbar_sel[5:4] stays 2 until the tail transfers; input 0 is granted after.
- Backpressure and bubbles: out_ready[1]=0 for 3 cycles, then in_valid drops for 2 cycles mid-packet -> in_accept=0 during these cycles and the lock is held. The tail completes after both conditions clear.
- en and illegal codes: en=0 with an IDLE request -> no grant until en=1. Code 3'd6 or EMPTY with valid head -> never granted, in_accept stays 0.
